// File: rtl/affine_driver.sv
// affine_driver: drives the picoMIPS switch inputs through one affine-transform
// transaction and checks the LED results against a fixed-point golden model.
module affine_driver #(
   parameter int          HOLD   = 5,
   parameter int          SETTLE = 20,
   parameter logic [7:0]  A11    = 8'h60,
   parameter logic [7:0]  A12    = 8'h40,
   parameter logic [7:0]  B1     = 8'h14,
   parameter logic [7:0]  A21    = 8'hC0,
   parameter logic [7:0]  A22    = 8'h60,
   parameter logic [7:0]  B2     = 8'hEC
) (
   input  logic        clk,
   input  logic        nReset,
   input  logic        start,
   input  logic [7:0]  x1_in,
   input  logic [7:0]  y1_in,
   input  logic [7:0]  led_in,
   output logic [8:0]  sw_out,
   output logic        cpu_nreset,
   output logic        busy,
   output logic        done,
   output logic [7:0]  x2_got,
   output logic [7:0]  y2_got,
   output logic        x2_ok,
   output logic        y2_ok
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_CRST    = 4'd1;
   localparam logic [3:0] S_X_SET   = 4'd2;
   localparam logic [3:0] S_X_STB   = 4'd3;
   localparam logic [3:0] S_Y_SET   = 4'd4;
   localparam logic [3:0] S_Y_STB   = 4'd5;
   localparam logic [3:0] S_COMPUTE = 4'd6;
   localparam logic [3:0] S_SHOW_X  = 4'd7;
   localparam logic [3:0] S_SHOW_Y  = 4'd8;
   localparam logic [3:0] S_REPORT  = 4'd9;

   logic [3:0]  r_state;
   logic [3:0]  w_next;
   logic [3:0]  w_succ;
   logic [15:0] r_cnt;
   logic [15:0] w_load;
   logic [7:0]  r_x1;
   logic [7:0]  r_y1;
   logic [3:0]  r_ph;
   logic        r_last;
   logic [8:0]  r_sw;
   logic [8:0]  w_sw;
   logic        r_cpu_nreset;
   logic        w_cpu_nreset;
   logic        r_busy;
   logic        r_done;
   logic [7:0]  r_x2_got;
   logic [7:0]  r_y2_got;
   logic        r_x2_ok;
   logic        r_y2_ok;
   logic [7:0]  w_x2_gold;
   logic [7:0]  w_y2_gold;
   logic [7:0]  w_y2_next;
   logic        w_x2_cap;
   logic        w_y2_cap;

   // Q1.7 coefficient times signed integer, keeping product bits [14:7]
   function automatic logic [7:0] fx_term(input logic [7:0] coef, input logic [7:0] opnd);
      logic signed [15:0] prod;
      prod = $signed({{8{coef[7]}}, coef}) * $signed({{8{opnd[7]}}, opnd});
      return 8'(prod >>> 7);
   endfunction

   assign w_x2_gold = fx_term(A11, r_x1) + fx_term(A12, r_y1) + B1;
   assign w_y2_gold = fx_term(A21, r_x1) + fx_term(A22, r_y1) + B2;

   // Next-state selection: each timed phase advances when its counter expires
   always_comb begin
      w_succ = S_IDLE;
      case (r_state)
         S_IDLE:    w_succ = S_CRST;
         S_CRST:    w_succ = S_X_SET;
         S_X_SET:   w_succ = S_X_STB;
         S_X_STB:   w_succ = S_Y_SET;
         S_Y_SET:   w_succ = S_Y_STB;
         S_Y_STB:   w_succ = S_COMPUTE;
         S_COMPUTE: w_succ = S_SHOW_X;
         S_SHOW_X:  w_succ = S_SHOW_Y;
         S_SHOW_Y:  w_succ = S_REPORT;
         S_REPORT:  w_succ = S_IDLE;
         default:   w_succ = S_IDLE;
      endcase
      if (r_state == S_IDLE) begin
         if (start) w_next = S_CRST;
         else       w_next = S_IDLE;
      end else if ((r_cnt == 16'd0) || (r_state > S_REPORT)) begin
         w_next = w_succ;
      end else begin
         w_next = r_state;
      end
   end

   // Phase length loaded on entry to each state
   always_comb begin
      w_load = 16'd0;
      case (w_next)
         S_COMPUTE:        w_load = 16'(SETTLE - 1);
         S_IDLE, S_REPORT: w_load = 16'd0;
         default:          w_load = 16'(HOLD - 1);
      endcase
   end

   // State register and phase down-counter
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_state <= S_IDLE;
         r_cnt   <= 16'd0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state) r_cnt <= w_load;
         else if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
         else r_cnt <= r_cnt;
      end
   end

   // Operand latch on an accepted start
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_x1 <= 8'h00;
         r_y1 <= 8'h00;
      end else if ((r_state == S_IDLE) && start) begin
         r_x1 <= x1_in;
         r_y1 <= y1_in;
      end else begin
         r_x1 <= r_x1;
         r_y1 <= r_y1;
      end
   end

   // Switch-side drive pattern for the current phase
   always_comb begin
      w_sw         = 9'h000;
      w_cpu_nreset = 1'b1;
      case (r_state)
         S_IDLE:    w_sw = 9'h000;
         S_CRST:    begin w_sw = 9'h000; w_cpu_nreset = 1'b0; end
         S_X_SET:   w_sw = {1'b0, r_x1};
         S_X_STB:   w_sw = {1'b1, r_x1};
         S_Y_SET:   w_sw = {1'b0, r_y1};
         S_Y_STB:   w_sw = {1'b1, r_y1};
         S_COMPUTE: w_sw = 9'h100;
         S_SHOW_X:  w_sw = 9'h000;
         S_SHOW_Y:  w_sw = 9'h100;
         S_REPORT:  w_sw = 9'h000;
         default:   w_sw = 9'h000;
      endcase
   end

   // Outputs trail the state by one cycle, so captures key off the visible phase
   assign w_x2_cap  = (r_ph == S_SHOW_X) && r_last;
   assign w_y2_cap  = (r_ph == S_SHOW_Y) && r_last;
   assign w_y2_next = w_y2_cap ? led_in : r_y2_got;

   // Registered outputs, LED capture and result check
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_ph         <= S_IDLE;
         r_last       <= 1'b0;
         r_sw         <= 9'h000;
         r_cpu_nreset <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_x2_got     <= 8'h00;
         r_y2_got     <= 8'h00;
         r_x2_ok      <= 1'b0;
         r_y2_ok      <= 1'b0;
      end else begin
         r_ph         <= r_state;
         r_last       <= (r_cnt == 16'd0);
         r_sw         <= w_sw;
         r_cpu_nreset <= w_cpu_nreset;
         r_busy       <= (r_state != S_IDLE);
         r_done       <= (r_state == S_REPORT);
         if (w_x2_cap) r_x2_got <= led_in;
         else          r_x2_got <= r_x2_got;
         r_y2_got <= w_y2_next;
         if (r_state == S_REPORT) begin
            r_x2_ok <= (r_x2_got == w_x2_gold);
            r_y2_ok <= (w_y2_next == w_y2_gold);
         end else begin
            r_x2_ok <= r_x2_ok;
            r_y2_ok <= r_y2_ok;
         end
      end
   end

   assign sw_out     = r_sw;
   assign cpu_nreset = r_cpu_nreset;
   assign busy       = r_busy;
   assign done       = r_done;
   assign x2_got     = r_x2_got;
   assign y2_got     = r_y2_got;
   assign x2_ok      = r_x2_ok;
   assign y2_ok      = r_y2_ok;

endmodule

// File: tb/tb_affine_driver.sv
// tb_affine_driver: directed checks of affine_driver against a behavioural
// picoMIPS model on the SW/LED bus, plus a short-phase waveform instance.
module tb_affine_driver;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       nReset, start, start2, fault;
   logic [7:0] x1, y1, led;
   logic [8:0] sw_out, sw2;
   logic       cpu_nreset, busy, done, x2_ok, y2_ok;
   logic       cpu_nreset2, busy2, done2, x2_ok2, y2_ok2;
   logic [7:0] x2_got, y2_got, x2_got2, y2_got2;
   int         n_checks = 0;
   int         n_pass   = 0;

   affine_driver dut (
      .clk(clk), .nReset(nReset), .start(start), .x1_in(x1), .y1_in(y1),
      .led_in(led), .sw_out(sw_out), .cpu_nreset(cpu_nreset), .busy(busy),
      .done(done), .x2_got(x2_got), .y2_got(y2_got), .x2_ok(x2_ok), .y2_ok(y2_ok)
   );

   affine_driver #(.HOLD(2), .SETTLE(3)) dut2 (
      .clk(clk), .nReset(nReset), .start(start2), .x1_in(x1), .y1_in(y1),
      .led_in(8'h00), .sw_out(sw2), .cpu_nreset(cpu_nreset2), .busy(busy2),
      .done(done2), .x2_got(x2_got2), .y2_got(y2_got2), .x2_ok(x2_ok2), .y2_ok(y2_ok2)
   );

   // Behavioural CPU: takes x1 then y1 on SW[8] rising edges, shows x2/y2 by SW[8]
   function automatic logic [7:0] mdl_term(input logic [7:0] c, input logic [7:0] v);
      int p;
      p = int'($signed(c)) * int'($signed(v));
      p = p >>> 7;
      return p[7:0];
   endfunction

   logic [7:0] m_x = 8'h00, m_y = 8'h00, m_x2, m_y2;
   logic [1:0] m_cnt = 2'd0;
   logic       m_prev = 1'b0;

   always @(posedge clk) begin
      if (!cpu_nreset) begin
         m_cnt  <= 2'd0;
         m_prev <= 1'b0;
      end else begin
         m_prev <= sw_out[8];
         if (sw_out[8] && !m_prev) begin
            if (m_cnt == 2'd0) begin m_x <= sw_out[7:0]; m_cnt <= 2'd1; end
            else if (m_cnt == 2'd1) begin m_y <= sw_out[7:0]; m_cnt <= 2'd2; end
         end
      end
   end

   assign m_x2 = mdl_term(8'h60, m_x) + mdl_term(8'h40, m_y) + 8'h14;
   assign m_y2 = mdl_term(8'hC0, m_x) + mdl_term(8'h60, m_y) + 8'hEC;
   assign led  = (m_cnt == 2'd2) ? (sw_out[8] ? m_y2 : (m_x2 ^ {7'd0, fault})) : 8'h00;

   task automatic run_txn(input logic [7:0] x, input logic [7:0] y, output int lat);
      @(posedge clk); #1;
      x1 = x; y1 = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      nReset = 1'b0; start = 1'b0; start2 = 1'b0; fault = 1'b0; x1 = 8'h00; y1 = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (sw_out !== 9'h000) $display("FAIL rst_sw_out: got %h expected 000", sw_out); else n_pass++;
      n_checks++; if (cpu_nreset !== 1'b0) $display("FAIL rst_cpu_nreset: got %b expected 0", cpu_nreset); else n_pass++;
      n_checks++; if ({busy, done} !== 2'b00) $display("FAIL rst_busy_done: got %b expected 00", {busy, done}); else n_pass++;
      n_checks++; if ({x2_got, y2_got} !== 16'h0000) $display("FAIL rst_got: got %h expected 0000", {x2_got, y2_got}); else n_pass++;
      n_checks++; if ({x2_ok, y2_ok} !== 2'b00) $display("FAIL rst_ok: got %b expected 00", {x2_ok, y2_ok}); else n_pass++;
      nReset = 1'b1;
      @(posedge clk); #1;
      n_checks++; if ({cpu_nreset, cpu_nreset2} !== 2'b11) $display("FAIL rel_cpu_nreset: got %b expected 11", {cpu_nreset, cpu_nreset2}); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rel_busy: got %b expected 0", busy); else n_pass++;
   endtask

   task automatic test_nominal;
      int lat;
      run_txn(8'h05, 8'hFB, lat);
      n_checks++; if (lat !== 56) $display("FAIL nom_latency: got %0d expected 56", lat); else n_pass++;
      n_checks++; if (x2_got !== 8'h14) $display("FAIL nom_x2: got %h expected 14", x2_got); else n_pass++;
      n_checks++; if (y2_got !== 8'hE5) $display("FAIL nom_y2: got %h expected e5", y2_got); else n_pass++;
      n_checks++; if ({x2_ok, y2_ok} !== 2'b11) $display("FAIL nom_ok: got %b expected 11", {x2_ok, y2_ok}); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL nom_busy_at_done: got %b expected 1", busy); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if ({busy, done} !== 2'b00) $display("FAIL nom_after_done: got %b expected 00", {busy, done}); else n_pass++;
   endtask

   task automatic test_wrap;
      int lat;
      run_txn(8'h7F, 8'h7F, lat);
      n_checks++; if ({x2_got, y2_got} !== 16'hB20B) $display("FAIL wrap_got: got %h expected b20b", {x2_got, y2_got}); else n_pass++;
      n_checks++; if ({x2_ok, y2_ok} !== 2'b11) $display("FAIL wrap_ok: got %b expected 11", {x2_ok, y2_ok}); else n_pass++;
   endtask

   task automatic test_zero;
      int lat;
      run_txn(8'h00, 8'h00, lat);
      n_checks++; if ({x2_got, y2_got} !== 16'h14EC) $display("FAIL zero_got: got %h expected 14ec", {x2_got, y2_got}); else n_pass++;
      n_checks++; if ({x2_ok, y2_ok} !== 2'b11) $display("FAIL zero_ok: got %b expected 11", {x2_ok, y2_ok}); else n_pass++;
   endtask

   task automatic test_fault;
      int lat;
      fault = 1'b1;
      run_txn(8'h05, 8'hFB, lat);
      fault = 1'b0;
      n_checks++; if (x2_got !== 8'h15) $display("FAIL fault_x2: got %h expected 15", x2_got); else n_pass++;
      n_checks++; if (y2_got !== 8'hE5) $display("FAIL fault_y2: got %h expected e5", y2_got); else n_pass++;
      n_checks++; if ({x2_ok, y2_ok} !== 2'b01) $display("FAIL fault_ok: got %b expected 01", {x2_ok, y2_ok}); else n_pass++;
   endtask

   task automatic test_back_to_back;
      int lat, n2;
      @(posedge clk); #1;
      x1 = 8'h7F; y1 = 8'h7F; start = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      n2 = 0;
      do begin
         @(posedge clk); #1;
         n2++;
      end while (done !== 1'b1 && n2 < 200);
      start = 1'b0;
      n_checks++; if (lat !== 56) $display("FAIL b2b_first_latency: got %0d expected 56", lat); else n_pass++;
      n_checks++; if (n2 !== 57) $display("FAIL b2b_done_spacing: got %0d expected 57", n2); else n_pass++;
      n_checks++; if ({x2_got, y2_got, x2_ok, y2_ok} !== 18'h2C82F) $display("FAIL b2b_result: got %h expected 2c82f", {x2_got, y2_got, x2_ok, y2_ok}); else n_pass++;
   endtask

   task automatic test_reset_mid;
      logic seen_done;
      @(posedge clk); #1;
      x1 = 8'h05; y1 = 8'hFB; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      n_checks++; if (sw_out !== 9'h100) $display("FAIL mid_compute_sw: got %h expected 100", sw_out); else n_pass++;
      nReset = 1'b0;
      #1;
      n_checks++; if ({sw_out, cpu_nreset, busy, done} !== 12'h000) $display("FAIL mid_rst_ctrl: got %h expected 000", {sw_out, cpu_nreset, busy, done}); else n_pass++;
      n_checks++; if ({x2_got, y2_got, x2_ok, y2_ok} !== 18'h00000) $display("FAIL mid_rst_results: got %h expected 00000", {x2_got, y2_got, x2_ok, y2_ok}); else n_pass++;
      seen_done = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen_done = 1'b1;
      end
      nReset = 1'b1;
      @(posedge clk); #1;
      n_checks++; if ({cpu_nreset, busy, sw_out} !== 11'h400) $display("FAIL mid_release: got %h expected 400", {cpu_nreset, busy, sw_out}); else n_pass++;
      repeat (60) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen_done = 1'b1;
      end
      n_checks++; if (seen_done !== 1'b0) $display("FAIL mid_no_done: got %b expected 0", seen_done); else n_pass++;
   endtask

   task automatic test_protocol;
      logic [0:16] exp_hs;
      logic [7:0]  exp_data;
      logic        early_done;
      exp_hs = 17'b00001100111110011;
      early_done = 1'b0;
      @(posedge clk); #1;
      x1 = 8'h12; y1 = 8'h34; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int i = 0; i < 17; i++) begin
         @(posedge clk); #1;
         if (i == 4) start2 = 1'b1;
         if (i == 5) start2 = 1'b0;
         n_checks++; if (sw2[8] !== exp_hs[i]) $display("FAIL proto_hs[%0d]: got %b expected %b", i, sw2[8], exp_hs[i]); else n_pass++;
         n_checks++; if (cpu_nreset2 !== (i >= 2)) $display("FAIL proto_cpu_nreset[%0d]: got %b expected %b", i, cpu_nreset2, (i >= 2)); else n_pass++;
         if (i < 13) begin
            exp_data = (i >= 2 && i < 6) ? 8'h12 : ((i >= 6 && i < 10) ? 8'h34 : 8'h00);
            n_checks++; if (sw2[7:0] !== exp_data) $display("FAIL proto_data[%0d]: got %h expected %h", i, sw2[7:0], exp_data); else n_pass++;
         end
         if (done2 === 1'b1) early_done = 1'b1;
      end
      n_checks++; if (early_done !== 1'b0) $display("FAIL proto_early_done: got %b expected 0", early_done); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if ({done2, busy2} !== 2'b11) $display("FAIL proto_done_18: got %b expected 11", {done2, busy2}); else n_pass++;
      repeat (5) begin
         @(posedge clk); #1;
         n_checks++; if ({done2, busy2} !== 2'b00) $display("FAIL proto_second_start_ignored: got %b expected 00", {done2, busy2}); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_wrap();
      test_zero();
      test_fault();
      test_back_to_back();
      test_reset_mid();
      test_protocol();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
